// File: rtl/effect_crossfade_ctrl_pkg.sv
// Shared types and width helpers for the effect-slot crossfade controller.
package effect_pkg;

    typedef enum logic [1:0] {
        DRY      = 2'd0,
        FADE_IN  = 2'd1,
        WET      = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    localparam int FADE_LOG2_MIN = 1;
    localparam int FADE_LOG2_MAX = 12;

    // Width of the weighted products and their sum. Sample width, plus the
    // gain magnitude bits, plus a sign bit and one carry bit for the sum.
    function automatic int mix_width(input int data_width, input int fade_log2);
        return data_width + fade_log2 + 2;
    endfunction

endpackage

// File: rtl/effect_crossfade_ctrl_if.sv
// Sample-stream bundle between the dry/wet sources, the controller and the next slot.
interface effect_crossfade_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    import effect_pkg::*;

    logic                         effect_enable;
    logic signed [DATA_WIDTH-1:0] dry_in;
    logic                         dry_valid;
    logic signed [DATA_WIDTH-1:0] wet_in;
    logic                         wet_valid;
    logic signed [DATA_WIDTH-1:0] audio_out;
    logic                         audio_out_valid;
    fade_state_t                  fade_state;
    logic                         align_error;

    modport master (
        output effect_enable, dry_in, dry_valid, wet_in, wet_valid,
        input  audio_out, audio_out_valid, fade_state, align_error
    );

    modport slave (
        input  effect_enable, dry_in, dry_valid, wet_in, wet_valid,
        output audio_out, audio_out_valid, fade_state, align_error
    );

endinterface

// File: rtl/effect_crossfade_ctrl_mixer.sv
// Combinational weighted sum: (wet*g + dry*(FULL-g)) >>> FADE_LOG2.
module crossfade_mixer
    import effect_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FADE_LOG2  = 8
) (
    input  logic signed [DATA_WIDTH-1:0] dry_in,
    input  logic signed [DATA_WIDTH-1:0] wet_in,
    input  logic        [FADE_LOG2:0]    gain,
    output logic signed [DATA_WIDTH-1:0] mix_out
);

    localparam int W  = mix_width(DATA_WIDTH, FADE_LOG2);
    localparam int GW = FADE_LOG2 + 1;
    localparam logic [GW-1:0] FULL_G = {1'b1, {FADE_LOG2{1'b0}}};

    logic        [GW-1:0] inv_gain;
    logic signed [W-1:0]  wet_x;
    logic signed [W-1:0]  dry_x;
    logic signed [W-1:0]  g_x;
    logic signed [W-1:0]  ig_x;
    logic signed [W-1:0]  sum;

    // Both gains are non-negative, so they are zero-extended into the signed
    // domain; samples are sign-extended. The arithmetic shift floors the result.
    always_comb begin
        inv_gain = FULL_G - gain;
        wet_x    = {{(W-DATA_WIDTH){wet_in[DATA_WIDTH-1]}}, wet_in};
        dry_x    = {{(W-DATA_WIDTH){dry_in[DATA_WIDTH-1]}}, dry_in};
        g_x      = {{(W-GW){1'b0}}, gain};
        ig_x     = {{(W-GW){1'b0}}, inv_gain};
        sum      = wet_x * g_x + dry_x * ig_x;
        mix_out  = DATA_WIDTH'(sum >>> FADE_LOG2);
    end

endmodule

// File: rtl/effect_crossfade_ctrl.sv
// Click-free enable/disable for one effect slot: crossfade FSM, gain counter
// and registered mixed output.
//
//  state    | meaning
//  ---------+--------------------------------------------------
//  DRY      | g = 0, output is the bypass sample
//  FADE_IN  | 0 < g < FULL, g rising one step per sample pair
//  WET      | g = FULL, output is the effect sample
//  FADE_OUT | 0 < g < FULL, g falling one step per sample pair
module effect_crossfade_ctrl
    import effect_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FADE_LOG2  = 8
) (
    input  logic clk,
    input  logic reset,
    effect_crossfade_ctrl_if.slave bus
);

    localparam int GW = FADE_LOG2 + 1;
    localparam logic [GW-1:0] FULL_G = {1'b1, {FADE_LOG2{1'b0}}};
    localparam logic [GW-1:0] ONE_G  = {{FADE_LOG2{1'b0}}, 1'b1};

    fade_state_t                  state_q;
    logic        [GW-1:0]         gain_q;
    logic signed [DATA_WIDTH-1:0] out_q;
    logic                         out_valid_q;
    logic                         align_q;
    logic signed [DATA_WIDTH-1:0] mix;
    logic                         pair;
    logic                         mismatch;

    assign pair     = bus.dry_valid & bus.wet_valid;
    assign mismatch = bus.dry_valid ^ bus.wet_valid;

    crossfade_mixer #(
        .DATA_WIDTH (DATA_WIDTH),
        .FADE_LOG2  (FADE_LOG2)
    ) u_mixer (
        .dry_in  (bus.dry_in),
        .wet_in  (bus.wet_in),
        .gain    (gain_q),
        .mix_out (mix)
    );

    // Fade sequencer: on each pair the output takes the mix at the old gain,
    // then gain and state step; a lone strobe only latches the sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DRY;
            gain_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            align_q     <= 1'b0;
        end else begin
            out_valid_q <= pair;
            if (mismatch) begin
                align_q <= 1'b1;
            end
            if (pair) begin
                out_q <= mix;
                case (state_q)
                    DRY: begin
                        if (bus.effect_enable) begin
                            state_q <= FADE_IN;
                            gain_q  <= ONE_G;
                        end
                    end
                    FADE_IN: begin
                        if (!bus.effect_enable) begin
                            gain_q  <= gain_q - ONE_G;
                            state_q <= (gain_q == ONE_G) ? DRY : FADE_OUT;
                        end else begin
                            gain_q  <= gain_q + ONE_G;
                            state_q <= (gain_q == FULL_G - ONE_G) ? WET : FADE_IN;
                        end
                    end
                    WET: begin
                        if (!bus.effect_enable) begin
                            state_q <= FADE_OUT;
                            gain_q  <= FULL_G - ONE_G;
                        end
                    end
                    FADE_OUT: begin
                        if (bus.effect_enable) begin
                            gain_q  <= gain_q + ONE_G;
                            state_q <= (gain_q == FULL_G - ONE_G) ? WET : FADE_IN;
                        end else begin
                            gain_q  <= gain_q - ONE_G;
                            state_q <= (gain_q == ONE_G) ? DRY : FADE_OUT;
                        end
                    end
                    default: begin
                        state_q <= DRY;
                        gain_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.audio_out       = out_q;
    assign bus.audio_out_valid = out_valid_q;
    assign bus.fade_state      = state_q;
    assign bus.align_error     = align_q;

endmodule
